// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: mode codes, bar palette,
// output pixel bundle and blanking-interval helpers.
package vga_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // Counter width; covers totals up to 2047 pixels/lines.
  localparam int unsigned CNT_W = 11;

  localparam logic [15:0] BAR_COLOURS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
  } vga_px_t;

  function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return line_total(act, fp, sync, bp);
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return line_total(act, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Mode controls in, video bundle out. The generator takes the master side,
// the DAC / consumer the slave side.
interface vga_pattern_gen_if;
  logic [1:0]  mode_sel;
  logic [15:0] solid_rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] rgb;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    input  mode_sel, solid_rgb,
    output hsync, vsync, de, rgb, pix_x, pix_y, frame_start, frame_cnt
  );

  modport slave (
    output mode_sel, solid_rgb,
    input  hsync, vsync, de, rgb, pix_x, pix_y, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_core.sv
// Horizontal/vertical position counters with combinational sync, visible-area
// and end-of-line / end-of-frame decode.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             line_last,
  output logic             frame_last
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  always_comb begin
    line_last  = (h_q == H_LAST);
    frame_last = line_last && (v_q == V_LAST);
    h_d = line_last ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (line_last) begin
      v_d = frame_last ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  assign active    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
  assign hsync_act = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign vsync_act = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus test-pattern generator. Mode and solid colour are shadowed at
// the last cycle of each frame; all video outputs leave one register after the counters.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned NUM_BARS    = 8,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input logic              vga_clk,
  input logic              sys_rst,
  vga_pattern_gen_if.master vif
);

  localparam int unsigned      BAR_W    = H_ACTIVE / NUM_BARS;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hsync_act, vsync_act, line_last, frame_last;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hsync_act  (hsync_act),
    .vsync_act  (vsync_act),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  logic [1:0]       mode_q, mode_d;
  logic [15:0]      solid_q, solid_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [7:0]       fcnt_out_q;
  logic [CNT_W-1:0] bar_px_q, bar_px_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  vga_px_t          px_q, px_d;

  logic [9:0]  x, y;
  logic        chk;
  logic [15:0] pat_rgb;

  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    fcnt_d  = fcnt_q;
    if (frame_last) begin
      mode_d  = vif.mode_sel;
      solid_d = vif.solid_rgb;
      fcnt_d  = fcnt_q + 8'd1;
    end
  end

  // Bar index tracks h_cnt / BAR_W incrementally instead of dividing.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (line_last) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (active) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  always_comb begin
    x   = h_cnt[9:0];
    y   = v_cnt[9:0];
    chk = x[CHECK_SHIFT] ^ y[CHECK_SHIFT];
    case (mode_q)
      MODE_BARS:  pat_rgb = BAR_COLOURS[bar_idx_q];
      MODE_CHECK: pat_rgb = {16{chk}};
      MODE_GRAD:  pat_rgb = {x[9:5], y[8:3], fcnt_q[4:0]};
      default:    pat_rgb = solid_q;
    endcase

    px_d             = '0;
    px_d.hsync       = hsync_act ? SYNC_POL : ~SYNC_POL;
    px_d.vsync       = vsync_act ? SYNC_POL : ~SYNC_POL;
    px_d.de          = active;
    px_d.rgb         = active ? pat_rgb : 16'h0000;
    px_d.pix_x       = active ? x : 10'd0;
    px_d.pix_y       = active ? y : 10'd0;
    px_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      mode_q     <= MODE_BARS;
      solid_q    <= 16'h0000;
      fcnt_q     <= 8'd0;
      fcnt_out_q <= 8'd0;
      bar_px_q   <= '0;
      bar_idx_q  <= '0;
      px_q       <= '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, default: '0};
    end else begin
      mode_q     <= mode_d;
      solid_q    <= solid_d;
      fcnt_q     <= fcnt_d;
      fcnt_out_q <= fcnt_q;
      bar_px_q   <= bar_px_d;
      bar_idx_q  <= bar_idx_d;
      px_q       <= px_d;
    end
  end

  assign vif.hsync       = px_q.hsync;
  assign vif.vsync       = px_q.vsync;
  assign vif.de          = px_q.de;
  assign vif.rgb         = px_q.rgb;
  assign vif.pix_x       = px_q.pix_x;
  assign vif.pix_y       = px_q.pix_y;
  assign vif.frame_start = px_q.frame_start;
  assign vif.frame_cnt   = fcnt_out_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: small-timing active-low instance for frame/pattern/reset checks,
// and a tiny active-high instance for sync polarity and frame counter wrap.
module tb_vga_pattern_gen;

  localparam int AH = 80;      // 64 + 4 + 8 + 4
  localparam int AV = 46;      // 40 + 2 + 2 + 2
  localparam int AF = AH * AV;
  localparam int BH = 12;      // 8 + 1 + 2 + 1
  localparam int BV = 7;       // 4 + 1 + 1 + 1
  localparam int BF = BH * BV;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  vga_pattern_gen_if if_a ();
  vga_pattern_gen_if if_b ();

  vga_pattern_gen #(
    .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (40), .V_FP (2), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b0), .NUM_BARS (8), .CHECK_SHIFT (5)
  ) dut_a (
    .vga_clk (clk),
    .sys_rst (rst_a),
    .vif     (if_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b1), .NUM_BARS (4), .CHECK_SHIFT (1)
  ) dut_b (
    .vga_clk (clk),
    .sys_rst (rst_b),
    .vif     (if_b)
  );

  int nvec = 0;
  int nbad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] img [0:39][0:63];
  int e_de, e_hs, e_vs, e_blank, e_pix, e_fs, n_de, n_hs, n_vs;

  // Walks one frame of instance A from its frame_start cycle, modelling timing.
  task automatic scan_a(input int chg_at, input logic [1:0] m, input logic [15:0] s);
    e_de = 0; e_hs = 0; e_vs = 0; e_blank = 0; e_pix = 0; e_fs = 0;
    n_de = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < AF; i++) begin
      int h;
      int v;
      logic exp_de, exp_hs, exp_vs, exp_fs;
      h = i % AH;
      v = i / AH;
      if (i == chg_at) begin
        if_a.mode_sel  = m;
        if_a.solid_rgb = s;
      end
      exp_de = (h < 64) && (v < 40);
      exp_hs = !((h >= 68) && (h < 76));
      exp_vs = !((v >= 42) && (v < 44));
      exp_fs = (i == 0);
      if (if_a.de !== exp_de) e_de++;
      if (if_a.hsync !== exp_hs) e_hs++;
      if (if_a.vsync !== exp_vs) e_vs++;
      if (if_a.frame_start !== exp_fs) e_fs++;
      if (if_a.de === 1'b1) n_de++;
      if (if_a.hsync === 1'b0) n_hs++;
      if (if_a.vsync === 1'b0) n_vs++;
      if (!exp_de && if_a.rgb !== 16'h0000) e_blank++;
      if (exp_de) begin
        if (if_a.pix_x !== 10'(h) || if_a.pix_y !== 10'(v)) e_pix++;
        img[v][h] = if_a.rgb;
      end else if (if_a.pix_x !== 10'd0 || if_a.pix_y !== 10'd0) begin
        e_pix++;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_scan(input string tag);
    check({tag, "_de"}, 32'(e_de), 32'd0);
    check({tag, "_hsync"}, 32'(e_hs), 32'd0);
    check({tag, "_vsync"}, 32'(e_vs), 32'd0);
    check({tag, "_fs"}, 32'(e_fs), 32'd0);
    check({tag, "_blank"}, 32'(e_blank), 32'd0);
    check({tag, "_pix"}, 32'(e_pix), 32'd0);
  endtask

  logic [15:0] row_b [0:7];
  int bh_hi, bv_hi, fs_bad, fc_bad, blue_bad;
  logic [7:0] fc255, fc256;
  logic [4:0] blue31, blue32;

  initial begin
    if_a.mode_sel = 2'd0; if_a.solid_rgb = 16'h0000;
    if_b.mode_sel = 2'd0; if_b.solid_rgb = 16'h0000;

    // Reset state, active-low instance
    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(if_a.hsync), 32'd1);
    check("rst_vsync", 32'(if_a.vsync), 32'd1);
    check("rst_de", 32'(if_a.de), 32'd0);
    check("rst_rgb", 32'(if_a.rgb), 32'h0);
    check("rst_pix_x", 32'(if_a.pix_x), 32'd0);
    check("rst_pix_y", 32'(if_a.pix_y), 32'd0);
    check("rst_fs", 32'(if_a.frame_start), 32'd0);
    check("rst_fcnt", 32'(if_a.frame_cnt), 32'd0);

    rst_a = 1'b0;
    @(negedge clk);
    check("rel_fs", 32'(if_a.frame_start), 32'd1);
    check("rel_de", 32'(if_a.de), 32'd1);
    check("rel_pix", {6'd0, if_a.pix_x, 6'd0, if_a.pix_y}, 32'd0);
    check("rel_rgb", 32'(if_a.rgb), 32'hFFFF);

    // Frame 0: bars; request solid F800 mid-frame (line 15)
    scan_a(15 * AH, 2'd3, 16'hF800);
    check_scan("f0");
    check("f0_n_de", 32'(n_de), 32'd2560);
    check("f0_n_hs", 32'(n_hs), 32'd368);
    check("f0_n_vs", 32'(n_vs), 32'd160);
    check("bar_x0", 32'(img[0][0]), 32'hFFFF);
    check("bar_x7", 32'(img[0][7]), 32'hFFFF);
    check("bar_x8", 32'(img[0][8]), 32'hFFE0);
    check("bar_x16", 32'(img[0][16]), 32'h07FF);
    check("bar_x40_y39", 32'(img[39][40]), 32'hF800);
    check("bar_x63_y20", 32'(img[20][63]), 32'h0000);
    check("f1_fs", 32'(if_a.frame_start), 32'd1);
    check("f1_fcnt", 32'(if_a.frame_cnt), 32'd1);
    check("f1_solid", 32'(if_a.rgb), 32'hF800);

    // Frame 1: solid; request checker
    scan_a(10, 2'd1, 16'h0000);
    check_scan("f1");
    check("solid_end", 32'(img[39][63]), 32'hF800);
    check("f2_fcnt", 32'(if_a.frame_cnt), 32'd2);

    // Frame 2: checker; request gradient
    scan_a(10, 2'd2, 16'h0000);
    check_scan("f2");
    check("chk_31_0", 32'(img[0][31]), 32'h0000);
    check("chk_32_0", 32'(img[0][32]), 32'hFFFF);
    check("chk_32_32", 32'(img[32][32]), 32'h0000);
    check("chk_0_32", 32'(img[32][0]), 32'hFFFF);
    check("f3_fcnt", 32'(if_a.frame_cnt), 32'd3);
    check("f3_rgb00", 32'(if_a.rgb), 32'h0003);

    // Frame 3: gradient with frame_cnt = 3
    scan_a(-1, 2'd2, 16'h0000);
    check_scan("f3");
    check("grad_63_39", 32'(img[39][63]), 32'h0883);
    check("grad_32_8", 32'(img[8][32]), 32'h0823);
    check("f4_rgb00", 32'(if_a.rgb), 32'h0004);

    // Mid-frame reset at line 20
    repeat (20 * AH + 5) @(negedge clk);
    check("mid_pix", {6'd0, if_a.pix_x, 6'd0, if_a.pix_y}, {6'd0, 10'd5, 6'd0, 10'd20});
    rst_a = 1'b1;
    @(negedge clk);
    check("mrst_de", 32'(if_a.de), 32'd0);
    check("mrst_rgb", 32'(if_a.rgb), 32'h0);
    check("mrst_hsync", 32'(if_a.hsync), 32'd1);
    check("mrst_vsync", 32'(if_a.vsync), 32'd1);
    check("mrst_pix", {6'd0, if_a.pix_x, 6'd0, if_a.pix_y}, 32'd0);
    check("mrst_fs", 32'(if_a.frame_start), 32'd0);
    check("mrst_fcnt", 32'(if_a.frame_cnt), 32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("mrel_fs", 32'(if_a.frame_start), 32'd1);
    check("mrel_pix", {6'd0, if_a.pix_x, 6'd0, if_a.pix_y}, 32'd0);
    check("mrel_fcnt", 32'(if_a.frame_cnt), 32'd0);
    check("mrel_mode_bars", 32'(if_a.rgb), 32'hFFFF);

    // Active-high instance: idle levels, bars, then gradient over 300 frames
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("b_rst_hsync", 32'(if_b.hsync), 32'd0);
    check("b_rst_vsync", 32'(if_b.vsync), 32'd0);
    if_b.mode_sel = 2'd2;
    rst_b = 1'b0;
    @(negedge clk);
    check("b_fs0", 32'(if_b.frame_start), 32'd1);
    bh_hi = 0; bv_hi = 0;
    for (int i = 0; i < BF; i++) begin
      if (i < 8) row_b[i] = if_b.rgb;
      if (if_b.hsync === 1'b1) bh_hi++;
      if (if_b.vsync === 1'b1) bv_hi++;
      @(negedge clk);
    end
    check("b_bar0", 32'(row_b[0]), 32'hFFFF);
    check("b_bar1", 32'(row_b[1]), 32'hFFFF);
    check("b_bar2", 32'(row_b[2]), 32'hFFE0);
    check("b_bar7", 32'(row_b[7]), 32'h07E0);
    check("b_hsync_hi", 32'(bh_hi), 32'd14);
    check("b_vsync_hi", 32'(bv_hi), 32'd12);

    fs_bad = 0; fc_bad = 0; blue_bad = 0;
    fc255 = 8'hxx; fc256 = 8'hxx; blue31 = 5'hxx; blue32 = 5'hxx;
    for (int k = 1; k <= 300; k++) begin
      if (if_b.frame_start !== 1'b1) fs_bad++;
      if (if_b.frame_cnt !== 8'(k)) fc_bad++;
      if (if_b.rgb !== {11'd0, 5'(k)}) blue_bad++;
      if (k == 255) fc255 = if_b.frame_cnt;
      if (k == 256) fc256 = if_b.frame_cnt;
      if (k == 31) blue31 = if_b.rgb[4:0];
      if (k == 32) blue32 = if_b.rgb[4:0];
      repeat (BF) @(negedge clk);
    end
    check("b_fs_period", 32'(fs_bad), 32'd0);
    check("b_fcnt_seq", 32'(fc_bad), 32'd0);
    check("b_blue_seq", 32'(blue_bad), 32'd0);
    check("b_fcnt_255", 32'(fc255), 32'd255);
    check("b_fcnt_wrap", 32'(fc256), 32'd0);
    check("b_blue_31", 32'(blue31), 32'd31);
    check("b_blue_wrap", 32'(blue32), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
